// File: rtl/rom_port_arbiter.sv
// Two-requester arbiter for the single shared ROM read port.
// Fixed priority with a starvation guard; one-cycle registered response routed to the winner.

module rom_port_resp (
  input  logic        clk,
  input  logic        rst,
  input  logic        gnt,
  input  logic        addrErr,
  input  logic [31:0] romDout,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);
  logic vld;
  logic errQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      errQ <= 1'b0;
    end else begin
      vld  <= gnt;
      errQ <= gnt & addrErr;
    end
  end

  // ROM data arrives the cycle after the grant; mask it for bad addresses.
  assign rvalid = vld;
  assign err    = errQ;
  assign rdata  = (vld && !errQ) ? romDout : 32'h0;
endmodule

module rom_port_arbiter #(
  parameter int ROM_WORDS   = 16,
  parameter int PRIORITY_M1 = 1,
  parameter int MAX_WAIT    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_dout
);
  localparam int NUM_PORTS = 2;
  localparam int HI = (PRIORITY_M1 != 0) ? 1 : 0;
  localparam int LO = 1 - HI;
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * ROM_WORDS);

  logic [NUM_PORTS-1:0]       req;
  logic [NUM_PORTS-1:0][31:0] addr;
  logic [NUM_PORTS-1:0]       gnt;
  logic [NUM_PORTS-1:0]       rvalid;
  logic [NUM_PORTS-1:0][31:0] rdata;
  logic [NUM_PORTS-1:0]       err;
  logic [CW-1:0]              waitCnt;
  logic [31:0]                lastAddr;
  logic [31:0]                grantAddr;
  logic                       anyGnt;
  logic                       addrErr;
  logic                       contend;
  logic                       forceLo;

  assign req     = {m1_req, m0_req};
  assign addr    = {m1_addr, m0_addr};
  assign contend = req[HI] && req[LO];
  assign forceLo = (MAX_WAIT != 0) && (waitCnt == CW'(MAX_WAIT));

  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (contend) begin
        if (forceLo) gnt[LO] = 1'b1;
        else         gnt[HI] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  assign anyGnt    = |gnt;
  assign grantAddr = gnt[1] ? addr[1] : addr[0];
  assign rom_addr  = anyGnt ? grantAddr : lastAddr;
  assign addrErr   = (grantAddr[1:0] != 2'b00) || (grantAddr >= ADDR_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastAddr <= 32'h0;
      waitCnt  <= '0;
    end else begin
      if (anyGnt) lastAddr <= grantAddr;
      // Counts only lost contended cycles; any other cycle resets the streak.
      if (MAX_WAIT == 0)                     waitCnt <= '0;
      else if (contend && gnt[HI])           waitCnt <= forceLo ? waitCnt : waitCnt + 1'b1;
      else                                   waitCnt <= '0;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    rom_port_resp u_resp (
      .clk     (clk),
      .rst     (rst),
      .gnt     (gnt[p]),
      .addrErr (addrErr),
      .romDout (rom_dout),
      .rvalid  (rvalid[p]),
      .rdata   (rdata[p]),
      .err     (err[p])
    );
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_rdata  = rdata[0];
  assign m1_rdata  = rdata[1];
  assign m0_err    = err[0];
  assign m1_err    = err[1];
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter; ROM model holds word k = k.

module tb_rom_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata, rom_addr, romDout;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastExp = 32'h0;

  always #5 clk = ~clk;

  // Registered ROM: word index k holds value k.
  always_ff @(posedge clk) romDout <= {2'b00, rom_addr[31:2]};

  rom_port_arbiter #(.ROM_WORDS(16), .PRIORITY_M1(1), .MAX_WAIT(3)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .rom_addr(rom_addr), .rom_dout(romDout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One arbitration cycle: drive, check grant/rom_addr, then check the response.
  task automatic step(input logic r0, input logic [31:0] a0, input logic r1,
                      input logic [31:0] a1, input logic [1:0] expG,
                      input logic expErr, input logic [31:0] expData);
    @(negedge clk);
    m0_req = r0; m0_addr = a0; m1_req = r1; m1_addr = a1;
    #1;
    chk("gnt", {30'h0, m1_gnt, m0_gnt}, {30'h0, expG});
    if (expG == 2'b01) lastExp = a0;
    else if (expG == 2'b10) lastExp = a1;
    chk("rom_addr", rom_addr, lastExp);
    @(posedge clk);
    #1;
    chk("rvalid", {30'h0, m1_rvalid, m0_rvalid}, {30'h0, expG});
    if (expG == 2'b01) begin
      chk("m0_rdata", m0_rdata, expData);
      chk("m0_err", {31'h0, m0_err}, {31'h0, expErr});
    end else if (expG == 2'b10) begin
      chk("m1_rdata", m1_rdata, expData);
      chk("m1_err", {31'h0, m1_err}, {31'h0, expErr});
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h0; m1_req = 1'b1; m1_addr = 32'h4;
    #12;
    chk("rst_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    chk("rst_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    chk("rst_err", {30'h0, m1_err, m0_err}, 32'h0);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    rst = 1'b0;

    // single M1 read, then idle holds last address
    step(0, 32'h0, 1, 32'h08, 2'b10, 0, 32'h2);
    step(0, 32'h0, 0, 32'h0, 2'b00, 0, 32'h0);

    // contention with starvation guard: M1 x3, M0, M1 x3, M0
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) step(1, 32'h04, 1, 32'h0C, 2'b01, 0, 32'h1);
      else            step(1, 32'h04, 1, 32'h0C, 2'b10, 0, 32'h3);
    end
    step(0, 32'h0, 0, 32'h0, 2'b00, 0, 32'h0);

    // out-of-range and misaligned
    step(1, 32'h40, 0, 32'h0, 2'b01, 1, 32'h0);
    step(1, 32'h06, 0, 32'h0, 2'b01, 1, 32'h0);
    step(1, 32'h3C, 0, 32'h0, 2'b01, 0, 32'hF);

    // back-to-back alternation
    step(1, 32'h00, 0, 32'h0, 2'b01, 0, 32'h0);
    step(0, 32'h0, 1, 32'h3C, 2'b10, 0, 32'hF);
    step(1, 32'h10, 0, 32'h0, 2'b01, 0, 32'h4);

    // build up wait count, then reset with a response in flight
    step(1, 32'h04, 1, 32'h0C, 2'b10, 0, 32'h3);
    step(1, 32'h04, 1, 32'h0C, 2'b10, 0, 32'h3);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    chk("rst_mid_rdata", m1_rdata, 32'h0);
    chk("rst_mid_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lastExp = 32'h0;
    step(0, 32'h0, 0, 32'h0, 2'b00, 0, 32'h0);
    step(0, 32'h0, 0, 32'h0, 2'b00, 0, 32'h0);
    // wait count restarted from zero: three M1 wins before M0
    step(1, 32'h04, 1, 32'h0C, 2'b10, 0, 32'h3);
    step(1, 32'h04, 1, 32'h0C, 2'b10, 0, 32'h3);
    step(1, 32'h04, 1, 32'h0C, 2'b10, 0, 32'h3);
    step(1, 32'h04, 1, 32'h0C, 2'b01, 0, 32'h1);
    step(0, 32'h0, 0, 32'h0, 2'b00, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
